// File: rtl/param_shift_register_pkg.sv
// ============================================================================
// Package : psr_pkg
// Brief   : Mode encodings and FSM states shared by param_shift_register.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package psr_pkg;

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHL   = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_ROL   = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_ASR   = 3'b110;
   localparam logic [2:0] MODE_BURST = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/param_shift_register_if.sv
// ============================================================================
// Interface : param_shift_register_if
// Brief     : Control/data bundle of param_shift_register (master drives).
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_shift_register_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic [2:0]       mode;
   logic             din;
   logic [WIDTH-1:0] pdin;
   logic [WIDTH-1:0] q;
   logic             dout;
   logic             busy;
   logic             done;

   modport master (
      output en, mode, din, pdin,
      input  q, dout, busy, done
   );

   modport slave (
      input  en, mode, din, pdin,
      output q, dout, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/param_shift_register_next_value.sv
// ============================================================================
// Module : psr_next_value
// Brief  : Combinational next-q / next-dout selector. Rotates exist only
//          when PSR_ROTATE_EN is defined; otherwise 011/100 act as HOLD.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module psr_next_value
   import psr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  wire logic [WIDTH-1:0] q,
   input  wire logic             din,
   input  wire logic [WIDTH-1:0] pdin,
   input  wire logic [2:0]       mode,
   output logic      [WIDTH-1:0] q_next,
   output logic                  dout_next,
   output logic                  dout_we
);

   always_comb begin
      q_next    = q;
      dout_next = 1'b0;
      dout_we   = 1'b0;
      case (mode)
         MODE_SHL: begin
            q_next    = {q[WIDTH-2:0], din};
            dout_next = q[WIDTH-1];
            dout_we   = 1'b1;
         end
         MODE_SHR: begin
            q_next    = {din, q[WIDTH-1:1]};
            dout_next = q[0];
            dout_we   = 1'b1;
         end
`ifdef PSR_ROTATE_EN
         MODE_ROL: begin
            q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
            dout_next = q[WIDTH-1];
            dout_we   = 1'b1;
         end
         MODE_ROR: begin
            q_next    = {q[0], q[WIDTH-1:1]};
            dout_next = q[0];
            dout_we   = 1'b1;
         end
`endif
         MODE_LOAD:  q_next = pdin;
         MODE_ASR: begin
            q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
            dout_next = q[0];
            dout_we   = 1'b1;
         end
         MODE_BURST: q_next = pdin;
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/param_shift_register.sv
// ============================================================================
// Module : param_shift_register
// Brief  : WIDTH-bit shift/rotate/load register with autonomous burst
//          serialiser. Optional feature macro: PSR_ROTATE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_shift_register
   import psr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input wire logic               clk,
   input wire logic               reset,
   param_shift_register_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     w_count_next;
   logic [WIDTH-1:0]  r_q;
   logic              r_dout;
   logic              r_busy;
   logic              r_done;
   logic              w_busy_next;
   logic              w_done_next;
   logic [2:0]        w_eff_mode;
   logic [WIDTH-1:0]  w_q_next;
   logic              w_dout_next;
   logic              w_dout_we;

   psr_next_value #(.WIDTH(WIDTH)) u_next (
      .q         (r_q),
      .din       (bus.din),
      .pdin      (bus.pdin),
      .mode      (w_eff_mode),
      .q_next    (w_q_next),
      .dout_next (w_dout_next),
      .dout_we   (w_dout_we)
   );

   // While shifting a burst the external mode is ignored and SHR is forced.
   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_busy_next  = r_busy;
      w_done_next  = 1'b0;
      w_eff_mode   = bus.mode;
      case (r_state)
         ST_IDLE: begin
            if (bus.mode == MODE_BURST) begin
               w_count_next = CW'(WIDTH);
               w_busy_next  = 1'b1;
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_eff_mode   = MODE_SHR;
            w_count_next = r_count - CW'(1);
            if (r_count == CW'(1)) begin
               w_busy_next  = 1'b0;
               w_done_next  = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_q     <= '0;
         r_dout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (bus.en) begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_q     <= w_q_next;
         if (w_dout_we) begin
            r_dout <= w_dout_next;
         end
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
      end else begin
         r_done  <= 1'b0;
      end
   end

   assign bus.q    = r_q;
   assign bus.dout = r_dout;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

`default_nettype wire

// File: doc/param_shift_register.md
# param_shift_register

Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with synchronous reset, clock enable, and eight operating modes. The modes are hold, logical shifts, rotates, parallel load, arithmetic shift and an autonomous burst-serialise mode. It is the general storage and serialisation primitive for the datapath blocks that follow, used wherever a plain flip-flop bank, shift chain or parallel-to-serial converter is needed.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  clock enable; when 0 all state holds, including during a burst
- mode  input  3  operation select, decoded only when not busy
- din  input  1  serial input bit
- pdin  input  WIDTH  parallel load data
- q  output  WIDTH  register contents
- dout  output  1  last bit shifted or rotated out (registered)
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse on the final burst shift

## Operation
- Reset (reset=1 at a rising edge) overrides everything, including en:
  - q=0, dout=0, busy=0, done=0, count=0, FSM=IDLE.
- Mode decode applies in IDLE with en=1:
  - 000 HOLD: no change.
  - 001 SHL: q <= {q[W-2:0], din}; dout <= q[W-1].
  - 010 SHR: q <= {din, q[W-1:1]}; dout <= q[0].
  - 011 ROL: q <= {q[W-2:0], q[W-1]}; dout <= q[W-1].
  - 100 ROR: q <= {q[0], q[W-1:1]}; dout <= q[0].
  - 101 LOAD: q <= pdin; dout unchanged.
  - 110 ASR: q <= {q[W-1], q[W-1:1]}; dout <= q[0].
  - 111 BURST: q <= pdin; count <= WIDTH; busy <= 1; FSM -> SHIFT.
- dout changes only on shift or rotate operations; it holds otherwise.
- FSM has two states, IDLE and SHIFT.
  - SHIFT, en=1: perform SHR (din into MSB, dout <= q[0]) and count <= count-1.
  - When the shift with count==1 executes: busy <= 0, done <= 1, FSM -> IDLE.
  - SHIFT, en=0: full stall; q, count, busy and dout hold, and done stays 0.
  - mode is ignored while busy=1. A burst cannot be retriggered until IDLE.
- done is 1 for exactly one cycle and is 0 in all other cycles.
- count width is $clog2(WIDTH+1), and count is unsigned.
- Reset asserted mid-burst aborts the burst on that edge. No done pulse is produced.

## Timing
- All outputs are registered, and every change is visible one cycle after the sampling edge.
- LOAD, shift and rotate latency is 1 cycle.
- Burst timing, for a burst triggered at edge 0 with en held high:
  - q=pdin and busy=1 after edge 0.
  - The WIDTH shifts occur at edges 1..WIDTH. dout after edge k equals pdin[k-1].
  - busy falls and done pulses after edge WIDTH.
  - A new mode is accepted at edge WIDTH+1.
- Each en=0 cycle during a burst extends the burst by one cycle.
- With en held high, burst throughput is one WIDTH-bit word per WIDTH+1 cycles.

## Configuration
- PSR_ROTATE_EN:
  - Defined: modes 011 and 100 rotate as specified above.
  - Undefined: modes 011 and 100 behave exactly as HOLD, with q and dout unchanged. The rotate mux is removed.

## Structure
- Shared package psr_pkg holds:
  - the mode encoding constants MODE_HOLD ... MODE_BURST (3-bit);
  - the FSM state encoding ST_IDLE, ST_SHIFT.
- A single sub-module, psr_next_value, is the combinational next-q/next-dout selector. It takes q, din, pdin and the effective mode.
- The top level holds the FSM, the counter and all registers.

## Test plan
All scenarios use WIDTH=8.
- Reset priority: load 0xA5, then assert reset with en=0 and mode=LOAD. After the edge, q=0x00, dout=0, busy=0 and done=0.
- Shifts: load 0x81, then apply SHL with din=0. The result is q=0x02 and dout=1. Then apply SHR with din=1, giving q=0x81 and dout=0. Then load 0x80 and apply ASR once, giving q=0xC0.
- Rotate: load 0x01 and apply ROR. With PSR_ROTATE_EN defined, q=0x80 and dout=1. Undefined, q=0x01 and dout holds its prior value.
- Burst: pdin=0xB4, mode=BURST, din=0, en=1.
  - Over 8 cycles, dout=0,0,1,0,1,1,0,1 and q ends at 0x00.
  - done pulses on the 8th shift and busy is low the next cycle.
  - mode=LOAD applied mid-burst is ignored.
- Burst stall: same stimulus as the burst scenario, with en=0 for 3 cycles after the 4th shift. busy is held, and done arrives 3 cycles later with the identical dout sequence.
- Reset mid-burst: assert reset after the 5th shift. The next cycle shows q=0, busy=0 and no done pulse, and a fresh LOAD is accepted on the following edge.
